// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register indices, exception codes,
// SR/Cause field positions and the packing helpers used for mfc0 reads.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int IP_LO    = 10;
    localparam int EXC_LO   = 2;
    localparam int CAUSE_BD = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } srReg_t;

    function automatic logic [31:0] packSr(input srReg_t sr);
        logic [31:0] word;
        word = '0;
        word[IM_LO +: 6] = sr.im;
        word[SR_EXL]     = sr.exl;
        word[SR_IE]      = sr.ie;
        return word;
    endfunction

    function automatic logic [31:0] packCause(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc);
        logic [31:0] word;
        word = '0;
        word[CAUSE_BD]    = bd;
        word[IP_LO +: 6]  = ip;
        word[EXC_LO +: 5] = exc;
        return word;
    endfunction

endpackage

// File: rtl/cp0_req_arbiter.sv
// Combinational request arbitration: decides whether an interrupt or exception is taken
// this cycle, which ExcCode gets recorded and which PC the handler returns to.
module cp0_req_arbiter
    import cp0_pkg::*;
(
    input  logic [5:0]  hwInt,
    input  srReg_t      sr,
    input  logic [4:0]  excCode,
    input  logic [31:0] pc,
`ifdef CP0_BD_EN
    input  logic        bd,
`endif
    output logic        intPend,
    output logic        excPend,
    output logic        intReq,
    output logic [4:0]  selExcCode,
    output logic [31:0] victimPc
);

    assign intPend = (|(hwInt & sr.im)) & sr.ie & ~sr.exl;
    assign excPend = (excCode != 5'd0) & ~sr.exl;
    assign intReq  = intPend | excPend;

    // Interrupts win over a synchronous exception in the same cycle.
    assign selExcCode = intPend ? EXC_INT : excCode;

`ifdef CP0_BD_EN
    // A delay-slot victim returns to the branch so the branch re-executes.
    assign victimPc = bd ? (pc - 32'd4) : pc;
`else
    assign victimPc = pc;
`endif

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: holds SR/Cause/EPC/PRId, raises IntReq and serves mfc0/mtc0/eret.
// Optional branch-delay tracking is enabled by defining CP0_BD_EN.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2019
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic [6:2]  ExcCode_M,
    input  logic        BD_M,
    input  logic [7:2]  HWInt,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    srReg_t      sr;
    logic [5:0]  causeIp;
    logic [4:0]  causeExc;
    logic        causeBd;
    logic [31:0] epcReg;

    logic        intPend;
    logic        excPend;
    logic        reqRaw;
    logic [4:0]  selExcCode;
    logic [31:0] victimPc;
    logic        srWrite;

    cp0_req_arbiter uArb (
        .hwInt      (HWInt),
        .sr         (sr),
        .excCode    (ExcCode_M),
        .pc         (PC_M),
`ifdef CP0_BD_EN
        .bd         (BD_M),
`endif
        .intPend    (intPend),
        .excPend    (excPend),
        .intReq     (reqRaw),
        .selExcCode (selExcCode),
        .victimPc   (victimPc)
    );

    assign IntReq  = reqRaw & reset;
    assign srWrite = WE && (A2 == REG_SR);
    assign EPC     = epcReg;

`ifndef CP0_BD_EN
    logic unusedBd;
    assign unusedBd = BD_M;
    assign causeBd  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr       <= '0;
            causeIp  <= '0;
            causeExc <= '0;
            epcReg   <= '0;
`ifdef CP0_BD_EN
            causeBd  <= 1'b0;
`endif
        end else begin
            causeIp <= HWInt;
            if (IntReq) begin
                sr.exl   <= 1'b1;
                causeExc <= selExcCode;
                epcReg   <= victimPc;
`ifdef CP0_BD_EN
                causeBd  <= BD_M;
`endif
            end else begin
                if (srWrite) begin
                    sr.im <= DIn[IM_LO +: 6];
                    sr.ie <= DIn[SR_IE];
                end
                // eret takes precedence over an mtc0 EXL write in the same cycle.
                if (srWrite || EXLClr)
                    sr.exl <= EXLClr ? 1'b0 : DIn[SR_EXL];
                if (WE && (A2 == REG_EPC))
                    epcReg <= {DIn[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = packSr(sr);
            REG_CAUSE: DOut = packCause(causeBd, causeIp, causeExc);
            REG_EPC:   DOut = epcReg;
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = '0;
        endcase
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the five-stage MIPS pipeline. Consumes the 5-bit exception code produced by the MEM-stage exception detector (AdEL = 4, AdES = 5, plus codes carried down the pipe), the MEM-stage PC and the external hardware interrupt lines. Arbitrates them into a single exception/interrupt request, latches SR/Cause/EPC, and serves `mfc0`/`mtc0`/`eret`. Sits directly downstream of the MEM-stage exception logic; its request output flushes the pipeline and redirects fetch to the handler.

## Interface
- `PRID_VALUE`, default 32'h0000_2019: read-only processor ID value.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `PC_M`  in  32  PC of the instruction in MEM.
- `ExcCode_M`  in  [6:2]  exception code of the MEM instruction; 0 = none.
- `BD_M`  in  1  MEM instruction is in a branch delay slot.
- `HWInt`  in  [7:2]  external interrupt lines, level-sensitive.
- `A1`  in  5  `mfc0` read register index.
- `A2`  in  5  `mtc0` write register index.
- `DIn`  in  32  `mtc0` write data.
- `WE`  in  1  `mtc0` write enable.
- `EXLClr`  in  1  `eret` in MEM; clears SR.EXL.
- `IntReq`  out  1  take exception/interrupt this cycle.
- `EPC`  out  32  current EPC register, the `eret` target.
- `DOut`  out  32  `mfc0` read data.

## Operation
- Registers: SR (12): IM[15:10], EXL[1], IE[0], all other bits read 0. Cause (13): BD[31], IP[15:10], ExcCode[6:2], other bits 0. EPC (14): 32 bits. PRId (15): `PRID_VALUE`.
- `int_pend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL`; `exc_pend = (ExcCode_M != 0) & ~SR.EXL`; `IntReq = int_pend | exc_pend`.
- Priority: an interrupt beats a synchronous exception. On an interrupt, Cause.ExcCode <= 0.
- On IntReq at the edge: SR.EXL <= 1; Cause.ExcCode <= (int_pend ? 0 : ExcCode_M); EPC <= victim PC (see Configuration); Cause.BD updated.
- Cause.IP <= HWInt on every edge, unconditionally, including during EXL.
- `mtc0`, when WE & ~IntReq: A2 = 12 writes IM/EXL/IE only. A2 = 14 writes EPC with DIn[31:2], 2'b00. A2 = 13 or 15 is ignored. The write is dropped when IntReq is high in the same cycle.
- EXLClr & ~IntReq: SR.EXL <= 0. IntReq cannot fire while EXL = 1, so the two never conflict in legal operation. If both are high, IntReq wins.
- `DOut` is a combinational read of A1: indices 12–15 as above, any other index returns 0. No write-to-read bypass.

## Timing
- Reset (asynchronous, active-low): SR, Cause and EPC go to 0. IntReq is forced 0 while reset = 0. DOut follows A1 on reset state. EPC output is 0.
- IntReq is combinational from the current state and inputs, with zero latency. Register effects are visible on the next cycle.
- `mfc0` after `mtc0` to the same register returns the new value one cycle later. The pipeline stalls or forwards as needed; this block does not.
- The EPC output is the register value only. An `eret` in the cycle after `mtc0 EPC` sees the new value.
- Reset released mid-handler: all state is restarted; no partial EXL is kept.

## Configuration
- `CP0_BD_EN` defined: Cause.BD <= BD_M on a take. The victim PC is PC_M − 4 when BD_M = 1, else PC_M, so the handler returns to the branch.
- Not defined: Cause.BD is tied to 0, BD_M is ignored, and the victim PC is always PC_M.

## Structure
- Shared package `cp0_pkg`:
  - register indices: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - exception codes: INT = 0, ADEL = 4, ADES = 5, RI = 10, OV = 12.
  - SR/Cause bit-field positions.
- One sub-module, `cp0_req_arbiter`: combinational logic that produces int_pend, exc_pend, IntReq, the selected ExcCode and the victim PC. Register state stays in `cp0_unit`.

## Test plan
- Reset held, ExcCode_M = 4 -> IntReq = 0. After release, with SR = 0, ExcCode_M = 4 and PC_M = 32'h3010 -> IntReq = 1; next cycle Cause.ExcCode = 4, EPC = 32'h3010, SR.EXL = 1.
- `mtc0 SR` with 32'h0000_0401 (IM[10] = 1, IE = 1), then HWInt[2] = 1 -> IntReq = 1, Cause.ExcCode = 0, Cause.IP[10] = 1.
- HWInt[2] = 1 and ExcCode_M = 5 in the same cycle with the interrupt enabled -> the interrupt is taken and ExcCode = 0.
- During EXL = 1, ExcCode_M = 4 -> IntReq = 0. Then EXLClr = 1 -> EXL = 0 next cycle, and EPC output is unchanged.
- `mtc0 EPC` with 32'h0000_3007 -> `mfc0 EPC` returns 32'h0000_3004. `mtc0` to Cause is ignored, and a read of A1 = 15 returns `PRID_VALUE`.
- With `CP0_BD_EN`: ExcCode_M = 5, PC_M = 32'h3020, BD_M = 1 -> EPC = 32'h301C and Cause.BD = 1. Without it: EPC = 32'h3020 and BD = 0.
